// File: rtl/conv_punct_encoder_pkg.sv
// Shared types and constants for the 802.11a K=7 convolutional encoder with puncturing.
package conv_punct_encoder_pkg;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SIGNAL = 2'd1, ST_DATA = 2'd2} state_t;
  typedef enum logic [1:0] {R12 = 2'd0, R23 = 2'd1, R34 = 2'd2} code_rate_t;

  typedef struct packed {
    code_rate_t rate;
    logic       err;
  } rate_dec_t;

  localparam int SIG_BITS_DEF = 24;

  localparam logic [3:0] RATE_6  = 4'b1101;
  localparam logic [3:0] RATE_9  = 4'b1111;
  localparam logic [3:0] RATE_12 = 4'b0101;
  localparam logic [3:0] RATE_18 = 4'b0111;
  localparam logic [3:0] RATE_24 = 4'b1001;
  localparam logic [3:0] RATE_36 = 4'b1011;
  localparam logic [3:0] RATE_48 = 4'b0001;
  localparam logic [3:0] RATE_54 = 4'b0011;

  // Tap masks over {s[5:0], in}: bit0 = current input, bit k = s[k-1].
  // These are g0=133o and g1=171o bit-reversed.
  localparam logic [6:0] G0_TAPS = 7'b1101101;
  localparam logic [6:0] G1_TAPS = 7'b1001111;

  function automatic rate_dec_t decode_rate(input logic [3:0] code);
    rate_dec_t d;
    d.rate = R12;
    d.err  = 1'b0;
    case (code)
      RATE_6, RATE_12, RATE_24:          d.rate = R12;
      RATE_48:                           d.rate = R23;
      RATE_9, RATE_18, RATE_36, RATE_54: d.rate = R34;
      default:                           d.err  = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] phase_max(input code_rate_t r);
    case (r)
      R23:     return 2'd1;
      R34:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/conv_k7_core.sv
// K=7 convolutional core: 6-bit shift register and the two generator outputs.
module conv_k7_core
  import conv_punct_encoder_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_bit,
  output logic o_a,
  output logic o_b
);

  logic [5:0] r_sr;
  logic [6:0] w_win;

  assign w_win = {r_sr, i_bit};
  assign o_a   = ^(w_win & G0_TAPS);
  assign o_b   = ^(w_win & G1_TAPS);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_sr <= '0;
    else if (i_clr) r_sr <= '0;
    else if (i_en)  r_sr <= {r_sr[4:0], i_bit};
  end

endmodule

// File: rtl/conv_punct_encoder.sv
// 802.11a convolutional encoder with rate 1/2, 2/3, 3/4 puncturing and a
// single-entry (A,B) holding register feeding a serial valid/ready output.
module conv_punct_encoder
  import conv_punct_encoder_pkg::*;
#(
  parameter int SIG_BITS = SIG_BITS_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [3:0] i_rate,
  input  logic       i_in_bit,
  input  logic       i_in_valid,
  input  logic       i_in_last,
  output logic       o_in_ready,
  output logic       o_out_bit,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_busy,
  output logic       o_rate_err
);

  localparam int CW = $clog2(SIG_BITS + 1);

  state_t     r_state;
  code_rate_t r_rate;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_phase;
  logic r_rate_err, r_ha, r_hb, r_va, r_vb, r_last_seen;
  logic w_in_xfer, w_out_xfer, w_a, w_b, w_pa, w_pb, w_va_n, w_vb_n, w_clr, w_active;
  rate_dec_t w_dec;

  assign w_dec       = decode_rate(i_rate);
  assign w_clr       = (r_state == ST_IDLE) && i_start;
  assign w_active    = (r_state != ST_IDLE) && !r_last_seen;
  assign o_out_valid = r_va | r_vb;
  assign o_out_bit   = r_va ? r_ha : r_hb;
  assign o_in_ready  = w_active && ((!r_va && !r_vb) || ((r_va ^ r_vb) && i_out_ready));
  assign w_in_xfer   = i_in_valid & o_in_ready;
  assign w_out_xfer  = o_out_valid & i_out_ready;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_rate_err  = r_rate_err;

  conv_k7_core u_core (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_en    (w_in_xfer),
    .i_bit   (i_in_bit),
    .o_a     (w_a),
    .o_b     (w_b)
  );

  // Which of A/B survive puncturing for the bit being accepted now.
  always_comb begin
    w_pa = 1'b1;
    w_pb = 1'b1;
    if (r_state == ST_DATA) begin
      case (r_rate)
        R23: if (r_phase == 2'd1) w_pb = 1'b0;
        R34: begin
          if (r_phase == 2'd1)      w_pb = 1'b0;
          else if (r_phase == 2'd2) w_pa = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A refill always coincides with the last held bit leaving, so it overwrites both flags.
  always_comb begin
    w_va_n = r_va;
    w_vb_n = r_vb;
    if (w_out_xfer) begin
      if (r_va) w_va_n = 1'b0;
      else      w_vb_n = 1'b0;
    end
    if (w_in_xfer) begin
      w_va_n = w_pa;
      w_vb_n = w_pb;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_rate      <= R12;
      r_cnt       <= '0;
      r_phase     <= '0;
      r_rate_err  <= 1'b0;
      r_ha        <= 1'b0;
      r_hb        <= 1'b0;
      r_va        <= 1'b0;
      r_vb        <= 1'b0;
      r_last_seen <= 1'b0;
    end else begin
      r_va <= w_va_n;
      r_vb <= w_vb_n;
      if (w_in_xfer) begin
        r_ha <= w_a;
        r_hb <= w_b;
      end
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_state     <= ST_SIGNAL;
          r_cnt       <= '0;
          r_phase     <= '0;
          r_rate      <= w_dec.rate;
          r_rate_err  <= w_dec.err;
          r_last_seen <= 1'b0;
        end
        ST_SIGNAL: if (w_in_xfer) begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(SIG_BITS - 1)) begin
            r_state <= ST_DATA;
            r_phase <= '0;
          end
        end
        ST_DATA: if (w_in_xfer)
          r_phase <= (r_phase == phase_max(r_rate)) ? 2'd0 : r_phase + 2'd1;
        default: r_state <= ST_IDLE;
      endcase
      if (w_in_xfer && i_in_last) r_last_seen <= 1'b1;
      if (r_last_seen && !w_va_n && !w_vb_n) begin
        r_state     <= ST_IDLE;
        r_last_seen <= 1'b0;
      end
    end
  end

endmodule
